// File: rtl/neuron_pkg.sv
// Shared types and constants for the spike routing fabric.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, RELEASE} arb_state_t;

  localparam int unsigned SYNC_MIN = 2;

endpackage

// File: rtl/req_sync.sv
// Multi-flop synchronizer bank for asynchronous handshake inputs, async active-low clear.
module req_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/spike_arbiter.sv
// Round-robin merge of N_IN 4-phase spike channels onto one downstream channel.
// Optional saturating spike counter enabled by defining SPIKE_ARB_CNT_EN.
module spike_arbiter
  import neuron_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_BITS    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          data_in,
  input  logic [N_IN-1:0]          req_in,
  output logic [N_IN-1:0]          ack_in,
  output logic                     data_out,
  output logic                     req_out,
  input  logic                     ack_out,
  output logic [$clog2(N_IN)-1:0]  grant,
  output logic                     busy
`ifdef SPIKE_ARB_CNT_EN
  ,
  output logic [CNT_BITS-1:0]      spike_cnt
`endif
);

  localparam int unsigned GW = $clog2(N_IN);

  if (N_IN < 2 || N_IN > 16) begin : g_bad_n_in
    $error("spike_arbiter: N_IN must be in 2..16");
  end
  if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
    $error("spike_arbiter: SYNC_STAGES below minimum");
  end
  if (CNT_BITS < 1) begin : g_bad_cnt
    $error("spike_arbiter: CNT_BITS must be at least 1");
  end

  arb_state_t      state;
  logic [N_IN-1:0] req_s;
  logic            ack_s;
  logic [N_IN-1:0] cand_c;
  logic [GW-1:0]   rr_idx_c;
  logic [GW-1:0]   pick_c;
  logic            pick_vld_c;

  req_sync #(.WIDTH(N_IN), .STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_in),
    .q     (req_s)
  );

  req_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_out),
    .q     (ack_s)
  );

  // Round-robin pick: scan from the channel after the last grant, wrapping.
  always_comb begin
    cand_c     = req_s & ~ack_in;
    rr_idx_c   = grant;
    pick_c     = grant;
    pick_vld_c = 1'b0;
    for (int unsigned k = 1; k <= N_IN; k++) begin
      rr_idx_c = GW'((32'(grant) + k) % N_IN);
      if (!pick_vld_c && cand_c[rr_idx_c]) begin
        pick_vld_c = 1'b1;
        pick_c     = rr_idx_c;
      end
    end
  end

  // One handshake at a time: grant, wait ack high, wait ack low, release requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= GW'(N_IN - 1);
      data_out <= 1'b0;
      req_out  <= 1'b0;
      ack_in   <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld_c) begin
            grant    <= pick_c;
            data_out <= data_in[pick_c];
            req_out  <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!ack_s) begin
            ack_in <= N_IN'(1) << grant;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (!req_s[grant]) begin
            ack_in <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPIKE_ARB_CNT_EN
  // Count delivered '1' spikes as the downstream acknowledges them; saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt <= '0;
    end else if (state == SEND && ack_s && data_out && spike_cnt != '1) begin
      spike_cnt <= spike_cnt + CNT_BITS'(1);
    end
  end
`endif

endmodule

// File: tb/tb_spike_arbiter.sv
// Directed bench for spike_arbiter: single-request vector table plus multi-cycle sequences.
module tb_spike_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned SS = 2;
`ifdef SPIKE_ARB_CNT_EN
  localparam int unsigned CB = 4;
`else
  localparam int unsigned CB = 8;
`endif
  localparam int BOUND = 5000;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] data_in;
  logic [N-1:0] req_in;
  logic [N-1:0] ack_in;
  logic         data_out;
  logic         req_out;
  logic         ack_out;
  logic [1:0]   grant;
  logic         busy;
`ifdef SPIKE_ARB_CNT_EN
  logic [CB-1:0] spike_cnt;
`endif

  spike_arbiter #(.N_IN(N), .SYNC_STAGES(SS), .CNT_BITS(CB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .req_in   (req_in),
    .ack_in   (ack_in),
    .data_out (data_out),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .grant    (grant),
    .busy     (busy)
`ifdef SPIKE_ARB_CNT_EN
    ,
    .spike_cnt(spike_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int   ch;
    logic dat;
    int   exp_lat;
    int   exp_grant;
    int   exp_data;
    int   exp_ack_lat;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  int dly, dcnt, tickno, fall_tick;
  int remaining [N];
  bit auto_en;
  logic [N-1:0] dat_pat;
  int order_q[$];
  int ack_q[$];
  int hi_q[$];
  logic prev_req_out;
  logic [N-1:0] prev_ack_in;
  int onehot_bad, reassert_bad, data_bad, hs_cnt, cur_hi;
  logic cur_data;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < int'(N); i++) s += remaining[i];
    return s;
  endfunction

  // One clock: monitor outputs, then step downstream and requester models.
  task automatic tick();
    @(negedge clk);
    tickno++;
    if ($countones(ack_in) > 1) onehot_bad++;
    if (req_out && !prev_req_out) begin
      hs_cnt++;
      order_q.push_back(int'(grant));
      if (ack_out) reassert_bad++;
      if (data_out !== dat_pat[grant]) data_bad++;
      cur_data = data_out;
      cur_hi = 0;
    end else if (req_out && prev_req_out) begin
      cur_hi++;
      if (data_out !== cur_data) data_bad++;
    end else if (!req_out && prev_req_out) begin
      hi_q.push_back(cur_hi);
    end
    for (int i = 0; i < int'(N); i++)
      if (ack_in[i] && !prev_ack_in[i]) ack_q.push_back(i);
    prev_req_out = req_out;
    prev_ack_in  = ack_in;

    if (req_out != ack_out) begin
      dcnt++;
      if (dcnt >= dly) begin
        ack_out = req_out;
        dcnt = 0;
        if (!req_out) fall_tick = tickno;
      end
    end else begin
      dcnt = 0;
    end

    if (auto_en) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req_in[i] && ack_in[i]) begin
          req_in[i] = 1'b0;
          remaining[i]--;
        end else if (!req_in[i] && !ack_in[i] && remaining[i] > 0) begin
          data_in[i] = dat_pat[i];
          req_in[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_logs();
    order_q.delete();
    ack_q.delete();
    hi_q.delete();
    onehot_bad = 0;
    reassert_bad = 0;
    data_bad = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_in = '0;
    data_in = '0;
    ack_out = 1'b0;
    dcnt = 0;
    for (int i = 0; i < int'(N); i++) remaining[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_until_done(input string name);
    int n = 0;
    while ((pending() > 0 || busy || req_in != '0 || ack_in != '0) && n < BOUND) begin
      tick();
      n++;
    end
    check(name, int'(n < BOUND), 1);
  endtask

  vec_t vecs [6];

  initial begin
    int n, lat, base;
    vecs[0] = '{ch: 2, dat: 1'b1, exp_lat: 3, exp_grant: 2, exp_data: 1, exp_ack_lat: 3};
    vecs[1] = '{ch: 0, dat: 1'b0, exp_lat: 3, exp_grant: 0, exp_data: 0, exp_ack_lat: 3};
    vecs[2] = '{ch: 3, dat: 1'b1, exp_lat: 3, exp_grant: 3, exp_data: 1, exp_ack_lat: 3};
    vecs[3] = '{ch: 1, dat: 1'b1, exp_lat: 3, exp_grant: 1, exp_data: 1, exp_ack_lat: 3};
    vecs[4] = '{ch: 1, dat: 1'b0, exp_lat: 3, exp_grant: 1, exp_data: 0, exp_ack_lat: 3};
    vecs[5] = '{ch: 0, dat: 1'b1, exp_lat: 3, exp_grant: 0, exp_data: 1, exp_ack_lat: 3};

    dly = 3; dcnt = 0; tickno = 0; fall_tick = 0;
    auto_en = 1'b0; dat_pat = '0; hs_cnt = 0; cur_hi = 0; cur_data = 1'b0;
    prev_req_out = 1'b0; prev_ack_in = '0;
    clear_logs();
    do_reset();
    tick();
    check("reset ack_in", int'(ack_in), 0);
    check("reset req_out", int'(req_out), 0);
    check("reset data_out", int'(data_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset grant", int'(grant), 3);

    // Table: isolated single requests on an idle arbiter.
    foreach (vecs[v]) begin
      dat_pat[vecs[v].ch] = vecs[v].dat;
      data_in[vecs[v].ch] = vecs[v].dat;
      req_in[vecs[v].ch]  = 1'b1;
      lat = 0;
      while (!req_out && lat < 100) begin tick(); lat++; end
      check($sformatf("v%0d req latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d grant", v), int'(grant), vecs[v].exp_grant);
      check($sformatf("v%0d data_out", v), int'(data_out), vecs[v].exp_data);
      n = 0;
      while (!ack_in[vecs[v].ch] && n < 200) begin tick(); n++; end
      check($sformatf("v%0d ack latency", v), tickno - fall_tick, vecs[v].exp_ack_lat);
      req_in[vecs[v].ch] = 1'b0;
      n = 0;
      while (ack_in[vecs[v].ch] && n < 200) begin tick(); n++; end
      check($sformatf("v%0d ack cleared", v), int'(ack_in), 0);
      check($sformatf("v%0d busy after", v), int'(busy), 0);
      tick();
    end

    // All four channels at once after reset: rotation 0,1,2,3.
    do_reset();
    clear_logs();
    auto_en = 1'b1;
    dat_pat = 4'b0110;
    base = hs_cnt;
    for (int i = 0; i < int'(N); i++) remaining[i] = 1;
    run_until_done("all4 completes");
    check("all4 handshakes", hs_cnt - base, 4);
    check("all4 order size", order_q.size(), 4);
    for (int i = 0; i < order_q.size() && i < 4; i++)
      check($sformatf("all4 order[%0d]", i), order_q[i], i);
    check("all4 onehot", onehot_bad, 0);
    check("all4 no reassert", reassert_bad, 0);
    check("all4 data", data_bad, 0);

    // Channels 1 and 3 re-requesting: strict alternation, 20 spikes.
    clear_logs();
    dat_pat = 4'b1010;
    remaining[1] = 10;
    remaining[3] = 10;
    run_until_done("alt completes");
    check("alt count", order_q.size(), 20);
    n = 0;
    for (int i = 0; i < order_q.size(); i++)
      if (order_q[i] != ((i % 2 == 0) ? 1 : 3)) n++;
    check("alt rotation errors", n, 0);
    check("alt onehot", onehot_bad, 0);

    // Reset asserted while in WAIT_LO.
    clear_logs();
    dat_pat = 4'b0101;
    base = hs_cnt;
    remaining[2] = 1;
    n = 0;
    while (!(hs_cnt == base + 1 && !req_out && busy && ack_in == '0) && n < 500) begin
      tick();
      n++;
    end
    check("wait_lo reached", int'(n < 500), 1);
    rst_n = 1'b0;
    #1;
    check("mid-reset req_out", int'(req_out), 0);
    check("mid-reset ack_in", int'(ack_in), 0);
    check("mid-reset busy", int'(busy), 0);
    check("mid-reset grant", int'(grant), 3);
    remaining[2] = 0;
    req_in = '0;
    ack_out = 1'b0;
    dcnt = 0;
    remaining[0] = 1;
    clear_logs();
    tick();
    tick();
    rst_n = 1'b1;
    run_until_done("post-reset completes");
    check("post-reset served", order_q.size(), 1);
    if (order_q.size() > 0) check("post-reset grant", order_q[0], 0);

    // Slow downstream with channels 0 and 1.
    do_reset();
    clear_logs();
    dly = 50;
    dat_pat = 4'b0001;
    remaining[0] = 1;
    remaining[1] = 1;
    run_until_done("slow completes");
    check("slow order size", order_q.size(), 2);
    if (order_q.size() == 2) begin
      check("slow first grant", order_q[0], 0);
      check("slow second grant", order_q[1], 1);
    end
    check("slow ack count", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      check("slow first ack", ack_q[0], 0);
      check("slow second ack", ack_q[1], 1);
    end
    if (hi_q.size() > 0) check("slow req held", int'(hi_q[0] >= 50), 1);
    else check("slow req held", 0, 1);
    check("slow data stable", data_bad, 0);
    dly = 3;

`ifdef SPIKE_ARB_CNT_EN
    // 20 one-spikes and 5 zero-spikes into a 4-bit counter: saturates at 15.
    do_reset();
    clear_logs();
    tick();
    check("cnt reset", int'(spike_cnt), 0);
    dat_pat = 4'b0001;
    remaining[0] = 20;
    remaining[1] = 5;
    run_until_done("cnt completes");
    check("cnt saturated", int'(spike_cnt), 15);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
